// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result bundle for the bit-serial subtractor
interface serial_subtractor_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial N-bit subtractor, LSB first, one bit per clock
module serial_subtractor #(
  parameter int N = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic           bor;
  logic [CW-1:0]  cnt;

  logic ai, bi, hd, d, bor_next;

  // Full-subtractor slice: two half-subtractor stages, borrows ORed.
  always_comb begin
    ai       = a_sh[0];
    bi       = b_sh[0];
    hd       = ai ^ bi;
    d        = hd ^ bor;
    bor_next = (~ai & bi) | (~hd & bor);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      a_sh           <= '0;
      b_sh           <= '0;
      bor            <= 1'b0;
      cnt            <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.diff       <= '0;
      bus.borrow_out <= 1'b0;
    end else begin
      case (state)
        // The edge leaving DONE may accept a new start, giving one operation per N+1 cycles.
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            bor      <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state    <= IDLE;
          end
        end
        RUN: begin
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          bus.diff <= {d, bus.diff[N-1:1]};
          bor      <= bor_next;
          cnt      <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            bus.borrow_out <= bor_next;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b1;
            state          <= DONE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.N(8)) sif ();
  serial_subtractor_if #(.N(4)) sif4 ();

  serial_subtractor #(.N(8)) dut  (.clk(clk), .rst(rst), .bus(sif.slave));
  serial_subtractor #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(sif4.slave));

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   done4_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse pops the oldest expected result.
  always @(negedge clk) begin
    if (!rst && sif.done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_done got=done exp=none at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_diff", 32'(sif.diff), 32'(e.d));
        chk("sb_borrow", 32'(sif.borrow_out), 32'(e.bo));
        chk("busy_done_excl", 32'(sif.busy), 32'd0);
      end
    end
    if (!rst && sif4.done) done4_cnt++;
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                      input logic eb, output int busy_cycles);
    int n;
    @(negedge clk);
    sif.a = a;
    sif.b = b;
    sif.start = 1'b1;
    sb.push_back({ed, eb});
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    sif.a = 8'($urandom);
    sif.b = 8'($urandom);
    busy_cycles = 0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (sif.done) break;
      if (sif.busy) busy_cycles++;
    end
    if (n == 20) chk("run8_timeout", 32'd1, 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(sif.done), 32'd0);
    chk("hold_diff", 32'(sif.diff), 32'(ed));
    chk("hold_borrow", 32'(sif.borrow_out), 32'(eb));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   bc;
    int   dtimes[$];
    vecs[0] = '{8'd9,   8'd5,   8'h04, 1'b0};
    vecs[1] = '{8'd5,   8'd9,   8'hFC, 1'b1};
    vecs[2] = '{8'h00,  8'hFF,  8'h01, 1'b1};
    vecs[3] = '{8'hAA,  8'hAA,  8'h00, 1'b0};
    vecs[4] = '{8'd200, 8'd100, 8'd100, 1'b0};
    vecs[5] = '{8'hFF,  8'h00,  8'hFF, 1'b0};
    vecs[6] = '{8'h00,  8'h01,  8'hFF, 1'b1};
    vecs[7] = '{8'h80,  8'h7F,  8'h01, 1'b0};

    rst = 1'b1;
    sif.start = 1'b0;  sif.a = '0;  sif.b = '0;
    sif4.start = 1'b0; sif4.a = '0; sif4.b = '0;
    #12;
    chk("rst_busy", 32'(sif.busy), 32'd0);
    chk("rst_done", 32'(sif.done), 32'd0);
    chk("rst_diff", 32'(sif.diff), 32'd0);
    chk("rst_borrow", 32'(sif.borrow_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, bc);
      chk("busy_cycles", 32'(bc), 32'd8);
    end

    // Result holds in IDLE with start low.
    run8(8'd5, 8'd9, 8'hFC, 1'b1, bc);
    repeat (5) @(negedge clk);
    chk("idle_hold_diff", 32'(sif.diff), 32'hFC);
    chk("idle_hold_borrow", 32'(sif.borrow_out), 32'd1);

    // start held high; operands scrambled while running, restored before each accept.
    for (int k = 0; k < 3; k++) sb.push_back({8'h02, 1'b0});
    @(negedge clk);
    sif.a = 8'd3; sif.b = 8'd1; sif.start = 1'b1;
    for (int c = 0; c < 40 && dtimes.size() < 3; c++) begin
      @(negedge clk);
      if (sif.done) begin
        dtimes.push_back(c);
        sif.a = 8'd3; sif.b = 8'd1;
        if (dtimes.size() == 3) sif.start = 1'b0;
      end else if (sif.busy) begin
        sif.a = 8'($urandom); sif.b = 8'($urandom);
      end
    end
    chk("held_start_dones", 32'(dtimes.size()), 32'd3);
    if (dtimes.size() == 3) begin
      chk("done_period_0", 32'(dtimes[1] - dtimes[0]), 32'd9);
      chk("done_period_1", 32'(dtimes[2] - dtimes[1]), 32'd9);
    end
    @(negedge clk);
    chk("held_end_busy", 32'(sif.busy), 32'd0);
    chk("held_end_done", 32'(sif.done), 32'd0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    sif.a = 8'd200; sif.b = 8'd100; sif.start = 1'b1;
    @(posedge clk);
    #1 sif.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(sif.busy), 32'd0);
    chk("arst_done", 32'(sif.done), 32'd0);
    chk("arst_diff", 32'(sif.diff), 32'd0);
    chk("arst_borrow", 32'(sif.borrow_out), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    run8(8'd200, 8'd100, 8'd100, 1'b0, bc);
    chk("post_rst_busy_cycles", 32'(bc), 32'd8);

    // N=4 exhaustive.
    done4_cnt = 0;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        logic [3:0] ea;
        logic [3:0] eb4;
        int n;
        ea  = 4'(x);
        eb4 = 4'(y);
        @(negedge clk);
        sif4.a = ea; sif4.b = eb4; sif4.start = 1'b1;
        @(posedge clk);
        #1 sif4.start = 1'b0;
        for (n = 0; n < 10; n++) begin
          @(negedge clk);
          if (sif4.done) break;
        end
        if (n == 10) chk("n4_timeout", 32'd1, 32'd0);
        chk("n4_diff", 32'(sif4.diff), 32'(4'(ea - eb4)));
        chk("n4_borrow", 32'(sif4.borrow_out), 32'(x < y));
      end
    end
    repeat (3) @(negedge clk);
    chk("n4_done_count", 32'(done4_cnt), 32'd256);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
